// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-cycle MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Ports: clk, rst (async, active-high); start/op/a/b launch an operation from IDLE;
//        busy while in flight; done (and dbz on divide-by-zero) pulse for one cycle
//        when hi/lo are written; hi = product upper half or remainder, lo = product
//        lower half or quotient.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic is_div, neg_lo, neg_hi, zero_div;
    logic [WIDTH-1:0] opnd;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0] a_mag, b_mag, hi_res, lo_res;
    logic [WIDTH:0] mul_sum, div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    assign busy = state != IDLE;
    always_comb begin
        state_nxt = state;
        if (state == IDLE && start)
            state_nxt = CALC;
        else if (state == CALC && cnt == CW'(WIDTH - 1))
            state_nxt = FIX;
        else if (state == FIX)
            state_nxt = IDLE;
    end
    always_comb begin
        a_mag    = (op[0] && a[WIDTH-1]) ? -a : a;
        b_mag    = (op[0] && b[WIDTH-1]) ? -b : b;
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        // remainder shifted left by one is the top WIDTH+1 bits before the shift
        div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
        prod_fix = neg_lo ? -acc : acc;
        // with a zero divisor every trial subtract succeeds, so the remainder ends as
        // |a| and the sign fix restores the raw dividend; only lo needs forcing
        hi_res   = is_div ? (neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH])
                          : prod_fix[2*WIDTH-1:WIDTH];
        lo_res   = is_div ? (zero_div ? '1 : (neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]))
                          : prod_fix[WIDTH-1:0];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            zero_div <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            dbz      <= 1'b0;
        end else begin
            done <= state == FIX;
            dbz  <= state == FIX && zero_div;
            if (state == IDLE && start) begin
                cnt      <= '0;
                is_div   <= op[1];
                neg_lo   <= op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_hi   <= op[0] && (op[1] ? a[WIDTH-1] : (a[WIDTH-1] ^ b[WIDTH-1]));
                zero_div <= op[1] && b == '0;
                opnd     <= b_mag;
                acc      <= op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                if (!op[1])
                    opnd <= a_mag;
            end else if (state == CALC) begin
                cnt <= cnt + 1'b1;
                if (is_div)
                    acc <= div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                           : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                else
                    acc <= acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
            end else if (state == FIX) begin
                hi <= hi_res;
                lo <= lo_res;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit with directed and random operations.
module tb_muldiv_unit;
    logic clk = 0, rst = 1, start = 0;
    logic [1:0] op = 0;
    logic [31:0] a = 0, b = 0;
    logic busy, done, dbz;
    logic [31:0] hi, lo;
    int cyc = 0, total = 0, passed = 0;
    typedef struct {
        logic [31:0] hi, lo;
        logic dbz;
        int cyc;
    } exp_t;
    exp_t q[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic exp_t model(logic [1:0] o, logic [31:0] x, logic [31:0] y);
        exp_t e;
        longint unsigned p;
        longint sp;
        e.dbz = 0; e.hi = 0; e.lo = 0; e.cyc = 0;
        if (o == 0) begin
            p = {32'b0, x} * {32'b0, y};
            {e.hi, e.lo} = p;
        end else if (o == 1) begin
            sp = longint'(int'(x)) * longint'(int'(y));
            {e.hi, e.lo} = sp;
        end else if (y == 0) begin
            e.lo = '1; e.hi = x; e.dbz = 1;
        end else if (o == 2) begin
            e.lo = x / y; e.hi = x % y;
        end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
            e.lo = x; e.hi = 0;
        end else begin
            e.lo = int'(x) / int'(y); e.hi = int'(x) % int'(y);
        end
        return e;
    endfunction

    // monitor: every done pops one expectation; a done with nothing pending is an error
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (q.size() == 0) check("unexpected_done", done, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    check("hi", hi, e.hi);
                    check("lo", lo, e.lo);
                    check("dbz", dbz, e.dbz);
                    check("latency", cyc - e.cyc, 33);
                    check("busy_at_done", busy, 0);
                end
            end else if (dbz) check("dbz_without_done", dbz, 0);
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", busy, 0);
    endtask

    task automatic issue(logic [1:0] o, logic [31:0] x, logic [31:0] y);
        exp_t e;
        wait_idle();
        start = 1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        e = model(o, x, y);
        e.cyc = cyc;
        q.push_back(e);
        start = 0; op = 2'($urandom); a = $urandom; b = $urandom;
        check("busy_after_start", busy, 1);
    endtask

    initial begin
        logic [31:0] corners [6];
        corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h12345678};
        #1;
        check("reset_busy", busy, 0);
        check("reset_hilo", {hi, lo}, 0);
        check("reset_done_dbz", {done, dbz}, 0);
        @(negedge clk);
        rst = 0;
        issue(0, 7, 6);
        issue(0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        issue(1, 32'hFFFFFFFD, 5);
        issue(3, 32'hFFFFFFF9, 2);
        issue(2, 100, 7);
        issue(3, 32'h80000000, 32'hFFFFFFFF);
        issue(2, 100, 0);
        issue(3, 32'h80000000, 0);
        issue(1, 32'h80000000, 32'h80000000);
        // second start while busy must be ignored
        issue(0, 32'h0000BEEF, 32'h00001234);
        repeat (9) @(negedge clk);
        start = 1; op = 2'b10; a = 32'hDEAD; b = 3;
        @(posedge clk);
        #1;
        start = 0;
        for (int i = 0; i < 24; i++) begin
            logic [31:0] x, y;
            x = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 7) == 0) y = 0;
            issue(2'($urandom_range(0, 3)), x, y);
        end
        // asynchronous reset in the middle of a divide
        issue(2, 32'hCAFEF00D, 13);
        repeat (15) @(posedge clk);
        #3 rst = 1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_hilo", {hi, lo}, 0);
        q.delete();
        @(negedge clk);
        rst = 0;
        repeat (40) @(negedge clk);
        check("no_done_after_rst", {hi, lo}, 0);
        issue(2, 1000, 33);
        issue(1, 32'hFFFFFFFF, 32'h7FFFFFFF);
        wait_idle();
        @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
